// File: rtl/cdbus_pkg.sv
// cdbus_pkg
// Shared types and constants for the CDBUS receive front-end.
// Contents: receiver state enum, default parameter widths, frame constants.
package cdbus_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int IDLE_W_DEF = 8;
  localparam int DATA_BITS  = 8;
  localparam int MIN_DIV    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_e;

endpackage : cdbus_pkg

// File: rtl/cdbus_rx_filter.sv
// cdbus_rx_filter
// Two-flop synchroniser on the raw rx pin, optional 3-sample majority
// filter, and falling-edge detect on the filtered line.
// Optional feature macro: RX_FILTER_EN (majority filter, +1 cycle latency).
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   async active-low reset
//   rx       in   raw bus line, asynchronous, idle high
//   rx_f     out  synchronised (and optionally filtered) line
//   fall     out  rx_f was 1 last cycle and is 0 now
module cdbus_rx_filter (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rx,
  output logic rx_f,
  output logic fall
);

  logic [1:0] sync_q;
  logic       rx_s;
  logic       rx_f_prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

`ifdef RX_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  // Majority of the current and two previous synchronised samples.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q <= 2'b11;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], rx_s};
      maj_q  <= (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign rx_f = maj_q;
`else
  assign rx_f = rx_s;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_f_prev_q <= 1'b1;
    else          rx_f_prev_q <= rx_f;
  end

  assign fall = rx_f_prev_q & ~rx_f;

endmodule : cdbus_rx_filter

// File: rtl/cdbus_rx_des.sv
// cdbus_rx_des
// Bit-level receive front-end: deserialises UART-style bytes (1 start,
// 8 data LSB-first, 1 stop), flags bad stop bits, and reports bus idle
// after idle_wait_i bit times of continuous high.
// Optional feature macro: RX_FILTER_EN (passed to cdbus_rx_filter).
// Ports:
//   clk_i         in   system clock
//   rst_n_i       in   async active-low reset
//   rx            in   raw bus line
//   div_i         in   clocks per bit minus 1 (>= 3), latched at start
//   idle_wait_i   in   idle bit times before bus_idle_o; 0 = immediate
//   data_o        out  last good byte
//   data_valid_o  out  one-cycle pulse with a new byte
//   frame_err_o   out  one-cycle pulse on a low stop bit
//   rx_busy_o     out  receiver outside IDLE
//   bus_idle_o    out  bus idle level
//
// state    | meaning
// ST_IDLE  | waiting for a falling edge; idle timer runs while line high
// ST_START | start bit, checked at mid-bit to reject glitches
// ST_DATA  | sampling 8 data bits LSB first
// ST_STOP  | stop bit sample; good byte or framing error
// ST_BRK   | line held low after a framing error; wait for high
module cdbus_rx_des
  import cdbus_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int IDLE_W = IDLE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rx,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [IDLE_W-1:0] idle_wait_i,
  output logic [7:0]        data_o,
  output logic              data_valid_o,
  output logic              frame_err_o,
  output logic              rx_busy_o,
  output logic              bus_idle_o
);

  rx_state_e         state_q, state_d;
  logic              rx_f, fall;
  logic [DIV_W-1:0]  div_l_q, cnt_q, idle_pre_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shreg_q, data_q;
  logic              valid_q, ferr_q, bus_idle_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              in_frame, tick, start_det;

  cdbus_rx_filter u_filter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rx      (rx),
    .rx_f    (rx_f),
    .fall    (fall)
  );

  assign in_frame  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  assign tick      = in_frame && (cnt_q == '0);
  assign start_det = (state_q == ST_IDLE) && fall;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall) state_d = ST_START;
      ST_START: if (tick) state_d = rx_f ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && (bit_idx_q == 3'(DATA_BITS - 1))) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = rx_f ? ST_IDLE : ST_BRK;
      ST_BRK:   if (rx_f) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bit timer: half a bit to reach mid-start, then a full bit per sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_l_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (start_det) begin
        div_l_q <= div_i;
        cnt_q   <= div_i >> 1;
      end else if (in_frame) begin
        if (cnt_q == '0) cnt_q <= div_l_q;
        else             cnt_q <= cnt_q - DIV_W'(1);
      end
      if (tick) begin
        case (state_q)
          ST_START: bit_idx_q <= '0;
          ST_DATA: begin
            shreg_q   <= {rx_f, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
          end
          ST_STOP: begin
            if (rx_f) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Idle detection: prescaler counts one bit time (div_i + 1 clocks), the
  // bit-time counter saturates once idle_wait_i is reached.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_pre_q <= '0;
      idle_cnt_q <= '0;
      bus_idle_q <= 1'b0;
    end else if (fall) begin
      idle_pre_q <= '0;
      idle_cnt_q <= '0;
      bus_idle_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && rx_f) begin
      if (idle_cnt_q >= idle_wait_i) begin
        bus_idle_q <= 1'b1;
      end else if (idle_pre_q >= div_i) begin
        idle_pre_q <= '0;
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      end else begin
        idle_pre_q <= idle_pre_q + DIV_W'(1);
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign rx_busy_o    = (state_q != ST_IDLE);
  assign bus_idle_o   = bus_idle_q;

endmodule : cdbus_rx_des

// File: tb/tb_cdbus_rx_des.sv
`timescale 1ns/1ps
module tb_cdbus_rx_des;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] div_i;
  logic [7:0]  idle_wait_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        frame_err_o;
  logic        rx_busy_o;
  logic        bus_idle_o;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   valid_times[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ferr_seen = 0;

  cdbus_rx_des dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rx           (rx),
    .div_i        (div_i),
    .idle_wait_i  (idle_wait_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .frame_err_o  (frame_err_o),
    .rx_busy_o    (rx_busy_o),
    .bus_idle_o   (bus_idle_o)
  );

  initial begin
    clk = 1'b0;
    forever #31.25 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: every output event must match the head of the queue.
  always @(negedge clk) begin
    if (data_valid_o || frame_err_o) begin
      exp_t e;
      if (data_valid_o) valid_times.push_back(cyc);
      if (frame_err_o) ferr_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b data=%0h expected none",
                 data_valid_o, frame_err_o, data_o);
      end else begin
        e = exp_q.pop_front();
        if ((data_valid_o === e.is_err) || (frame_err_o !== e.is_err) || (data_o !== e.data)) begin
          n_err++;
          $display("FAIL event: got valid=%0b err=%0b data=%0h expected err=%0b data=%0h",
                   data_valid_o, frame_err_o, data_o, e.is_err, e.data);
        end
      end
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic idle_gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; optionally checks bus_idle_o clears early in the start
  // bit, and optionally changes div_i after the start bit.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int div,
                           input bit chk_idle, input int new_div);
    int first_clr;
    first_clr = 0;
    rx = 1'b0;
    for (int i = 1; i <= div + 1; i++) begin
      @(negedge clk);
      if (chk_idle && first_clr == 0 && !bus_idle_o) first_clr = i;
    end
    if (chk_idle) check_range("bus_idle_clear_delay", first_clr, 1, 4);
    if (new_div != 0) div_i = 16'(new_div);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (div + 1) @(negedge clk);
    end
    rx = stop;
    repeat (div + 1) @(negedge clk);
  endtask

  initial begin
    int n;
    int idx;
    int busy_seen;
    rx          = 1'b1;
    div_i       = 16'd15;
    idle_wait_i = 8'd10;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_data_o", data_o, 8'h00);
    check("rst_valid", data_valid_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_busy", rx_busy_o, 1'b0);
    check("rst_bus_idle", bus_idle_o, 1'b0);

    // Idle detection from reset release: ten 16-cycle bit times.
    rst_n = 1'b1;
    n = 0;
    while (!bus_idle_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_range("bus_idle_rise", n, 156, 164);
    check("bus_idle_level", bus_idle_o, 1'b1);

    // Single byte.
    expect_byte(8'hA5);
    send_byte(8'hA5, 1'b1, 15, 1'b1, 0);
    idle_gap(20);
    check("single_data_o", data_o, 8'hA5);

    // Back-to-back with no gap.
    idx = valid_times.size();
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_byte(8'h00, 1'b1, 15, 1'b0, 0);
    send_byte(8'hFF, 1'b1, 15, 1'b0, 0);
    idle_gap(20);
    if (valid_times.size() >= idx + 2)
      check("b2b_spacing", valid_times[idx+1] - valid_times[idx], 160);
    else
      check("b2b_count", valid_times.size() - idx, 2);

    // Framing error followed by a 40-bit break.
    idx = ferr_seen;
    expect_err(8'hFF);
    send_byte(8'h3C, 1'b0, 15, 1'b0, 0);
    repeat (40 * 16) @(negedge clk);
    check("brk_busy_high", rx_busy_o, 1'b1);
    check("brk_data_kept", data_o, 8'hFF);
    check("brk_one_ferr", ferr_seen - idx, 1);
    rx = 1'b1;
    n = 0;
    while (rx_busy_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_range("brk_release", n, 1, 5);
    idle_gap(40);

    // False start: 4-cycle low pulse.
    busy_seen = 0;
    rx = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 4) rx = 1'b1;
      if (rx_busy_o) busy_seen = 1;
    end
    check("false_start_seen", busy_seen, 1);
    check("false_start_busy_low", rx_busy_o, 1'b0);
    idle_gap(30);

`ifdef RX_FILTER_EN
    busy_seen = 0;
    rx = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      rx = 1'b1;
      if (rx_busy_o) busy_seen = 1;
    end
    check("glitch_filtered", busy_seen, 0);
`else
    rx = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
    check("glitch_rejected", rx_busy_o, 1'b0);
`endif
    idle_gap(30);

    // Divisor 7, with div_i changed mid-frame: the latched value must hold.
    div_i = 16'd7;
    expect_byte(8'hC3);
    send_byte(8'hC3, 1'b1, 7, 1'b0, 20);
    idle_gap(30);
    check("div_latch_data", data_o, 8'hC3);
    div_i = 16'd15;
    idle_gap(20);

    // Reset during DATA bit 3.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx = k[0];
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy_before", rx_busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_o", data_o, 8'h00);
    check("mid_rst_valid", data_valid_o, 1'b0);
    check("mid_rst_ferr", frame_err_o, 1'b0);
    check("mid_rst_busy", rx_busy_o, 1'b0);
    check("mid_rst_bus_idle", bus_idle_o, 1'b0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle_gap(20);
    expect_byte(8'h5A);
    send_byte(8'h5A, 1'b1, 15, 1'b0, 0);
    idle_gap(30);
    check("after_rst_data_o", data_o, 8'h5A);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(62.5 * 60000);
    $display("FAIL timeout: got no completion expected finish within 60000 cycles");
    $fatal(1, "timeout");
  end

endmodule : tb_cdbus_rx_des
